// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Handshaked EX-stage ALU. Single-cycle logic/arithmetic ops with
//             NZCV flags, an iterative shift-add multiplier, a pass-through
//             destination tag, flush, and valid/ready flow control on both
//             sides. One operation is in flight at a time.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_cmd,
    input  logic [WIDTH-1:0] i_val1,
    input  logic [WIDTH-1:0] i_val2,
    input  logic             i_carry_in,
    input  logic [TAG_W-1:0] i_tag_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_n,
    output logic             o_z,
    output logic             o_c,
    output logic             o_v,
    output logic [TAG_W-1:0] o_tag_out,
    output logic             o_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [3:0] c_OP_MOV = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_ADC = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0100;
    localparam logic [3:0] c_OP_SBC = 4'b0101;
    localparam logic [3:0] c_OP_AND = 4'b0110;
    localparam logic [3:0] c_OP_ORR = 4'b0111;
    localparam logic [3:0] c_OP_EOR = 4'b1000;
    localparam logic [3:0] c_OP_MVN = 4'b1001;
    localparam logic [3:0] c_OP_MUL = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_MDONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;

    // Multiplier working set
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic               r_mcarry;
    logic [TAG_W-1:0]   r_mtag;
    logic [c_CNT_W-1:0] r_cnt;

    // Output register
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_n;
    logic               r_z;
    logic               r_c;
    logic               r_v;
    logic [TAG_W-1:0]   r_tag;
    logic               r_err;

    // Holds in_ready low for the first cycle after reset release
    logic               r_rdy_en;

    // Handshake helpers
    logic               w_free;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_last;
    logic               w_mul_wr;

    // Single-cycle datapath
    logic               w_add_cin;
    logic               w_sub_bor;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_v_add;
    logic               w_v_sub;
    logic [WIDTH-1:0]   w_ss_result;
    logic               w_ss_c;
    logic               w_ss_v;
    logic               w_ss_err;

    // Multiplier datapath
    logic [WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]   w_mul_prod;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // The output slot is free when empty or being drained on this edge.
    assign w_free     = !r_out_valid || i_out_ready;
    assign o_in_ready = r_rdy_en && (r_state == S_IDLE) && w_free && !i_flush;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_is_mul   = (i_cmd == c_OP_MUL);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == c_LAST);

    // ------------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------------
    assign w_add_cin = (i_cmd == c_OP_ADC) && i_carry_in;
    assign w_sub_bor = (i_cmd == c_OP_SBC) && !i_carry_in;

    // Carry/borrow come out of the extra top bit of the WIDTH+1 bit results.
    assign w_sum  = {1'b0, i_val1} + {1'b0, i_val2} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_diff = {1'b0, i_val1} - {1'b0, i_val2} - {{WIDTH{1'b0}}, w_sub_bor};

    assign w_v_add = (i_val1[WIDTH-1] == i_val2[WIDTH-1]) &&
                     (w_sum[WIDTH-1]  != i_val1[WIDTH-1]);
    assign w_v_sub = (i_val1[WIDTH-1] != i_val2[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != i_val1[WIDTH-1]);

    // Decode the opcode into a result plus C/V; illegal codes yield zero and err.
    always_comb begin
        w_ss_result = '0;
        w_ss_c      = i_carry_in;
        w_ss_v      = 1'b0;
        w_ss_err    = 1'b0;
        case (i_cmd)
            c_OP_MOV: w_ss_result = i_val2;
            c_OP_MVN: w_ss_result = ~i_val2;
            c_OP_ADD,
            c_OP_ADC: begin
                w_ss_result = w_sum[WIDTH-1:0];
                w_ss_c      = w_sum[WIDTH];
                w_ss_v      = w_v_add;
            end
            c_OP_SUB,
            c_OP_SBC: begin
                w_ss_result = w_diff[WIDTH-1:0];
                w_ss_c      = !w_diff[WIDTH];
                w_ss_v      = w_v_sub;
            end
            c_OP_AND: w_ss_result = i_val1 & i_val2;
            c_OP_ORR: w_ss_result = i_val1 | i_val2;
            c_OP_EOR: w_ss_result = i_val1 ^ i_val2;
            c_OP_MUL: w_ss_result = '0;
            default:  w_ss_err    = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Multiplier datapath
    // ------------------------------------------------------------------------
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

    // On the final iteration the product includes this cycle's partial sum.
    assign w_mul_prod = (r_state == S_MUL) ? w_acc_step : r_acc;

    // Multiplier registers: load on accept, one shift-add per cycle in S_MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mcarry <= 1'b0;
            r_mtag   <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= i_val1;
            r_mplier <= i_val2;
            r_acc    <= '0;
            r_mcarry <= i_carry_in;
            r_mtag   <= i_tag_in;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and product-write strobe; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_mul_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    if (w_free) begin
                        w_state_nxt = S_IDLE;
                        w_mul_wr    = 1'b1;
                    end else begin
                        w_state_nxt = S_MDONE;
                    end
                end
            end
            S_MDONE: begin
                if (w_free) begin
                    w_state_nxt = S_IDLE;
                    w_mul_wr    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = S_IDLE;
            w_mul_wr    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    // Load a single-cycle result or a finished product; otherwise drain on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_tag       <= '0;
            r_err       <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_ss_result;
            r_n         <= w_ss_result[WIDTH-1];
            r_z         <= (w_ss_result == '0);
            r_c         <= w_ss_c;
            r_v         <= w_ss_v;
            r_tag       <= i_tag_in;
            r_err       <= w_ss_err;
        end else if (w_mul_wr) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_prod;
            r_n         <= w_mul_prod[WIDTH-1];
            r_z         <= (w_mul_prod == '0);
            r_c         <= r_mcarry;
            r_v         <= 1'b0;
            r_tag       <= r_mtag;
            r_err       <= 1'b0;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // in_ready enable: low during reset, high from the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_n         = r_n;
    assign o_z         = r_z;
    assign o_c         = r_c;
    assign o_v         = r_v;
    assign o_tag_out   = r_tag;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Self-checking bench for alu_pipe: directed vector table,
//             hand-written flow-control/flush/reset sequences, and a random
//             phase scored against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam longint UMAX = 64'sd4294967295;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    cmd = 4'h0;
    logic [W-1:0]  val1 = '0;
    logic [W-1:0]  val2 = '0;
    logic          carry_in = 1'b0;
    logic [TW-1:0] tag_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          n, z, c, v;
    logic [TW-1:0] tag_out;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_cmd      (cmd),
        .i_val1     (val1),
        .i_val2     (val2),
        .i_carry_in (carry_in),
        .i_tag_in   (tag_in),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_result   (result),
        .o_n        (n),
        .o_z        (z),
        .o_c        (c),
        .o_v        (v),
        .o_tag_out  (tag_out),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0]  res;
        logic          n, z, c, v, err;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic [3:0]    cmd;
        logic [W-1:0]  a, b;
        logic          cin;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          n, z, c, v, err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [TW-1:0] tg);
        cmd      = op;
        val1     = a;
        val2     = b;
        carry_in = cin;
        tag_in   = tg;
        in_valid = 1'b1;
    endtask

    // Behavioural reference: plain wide arithmetic on integer values.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin,
                                   input logic [TW-1:0] tg);
        exp_t        e;
        longint      ua, ub, sa, sb, r, s, k;
        logic [63:0] p;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.c = cin; e.v = 1'b0; e.err = 1'b0; e.tag = tg;
        case (op)
            4'h1: e.res = b;
            4'h9: e.res = ~b;
            4'h2, 4'h3: begin
                k = (op == 4'h3 && cin) ? 1 : 0;
                r = ua + ub + k;
                s = sa + sb + k;
                e.res = r[31:0];
                e.c = (r > UMAX);
                e.v = (s > SMAX) || (s < SMIN);
            end
            4'h4, 4'h5: begin
                k = (op == 4'h5 && !cin) ? 1 : 0;
                r = ua - ub - k;
                s = sa - sb - k;
                e.res = r[31:0];
                e.c = (r >= 0);
                e.v = (s > SMAX) || (s < SMIN);
            end
            4'h6: e.res = a & b;
            4'h7: e.res = a | b;
            4'h8: e.res = a ^ b;
            4'hA: begin
                p = 64'(a) * 64'(b);
                e.res = p[31:0];
            end
            default: e.err = 1'b1;
        endcase
        e.n = e.res[W-1];
        e.z = (e.res == 0);
        return e;
    endfunction

    vec_t vecs[16];
    exp_t q[$];

    initial begin
        int   cyc;
        logic rdy_low;
        logic stayed_low;
        int   accepts;
        exp_t e;

        // ---------------- vector table ----------------
        //            cmd    a             b             cin   tag    res           n     z     c     v     err
        vecs[0]  = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'h1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'h2, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'h4, 32'h00000005, 32'h00000007, 1'b1, 4'h3, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'h5, 32'h0000000A, 32'h00000003, 1'b0, 4'h4, 32'h00000006, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'h3, 32'h00000001, 32'h00000001, 1'b1, 4'h5, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'h1, 32'h00000000, 32'h12345678, 1'b1, 4'h6, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'h9, 32'h0000FFFF, 32'h00000000, 1'b0, 4'h7, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 4'h8, 32'hF000F000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'h7, 32'h0000000F, 32'h000000F0, 1'b0, 4'h9, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'h8, 32'hAAAA5555, 32'hAAAA5555, 1'b1, 4'hA, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'hF, 32'h00000123, 32'h00000456, 1'b1, 4'hB, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'hC, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{4'h4, 32'h80000000, 32'h00000001, 1'b0, 4'hD, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{4'hA, 32'h000004D2, 32'h0000162E, 1'b1, 4'hE, 32'h006AE9BC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{4'hA, 32'h80000000, 32'h00000002, 1'b0, 4'hF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // ---------------- reset ----------------
        tick(); tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset flags", {n, z, c, v, err}, 0);
        chk("reset tag", tag_out, 0);
        chk("reset in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", in_ready, 0);
        tick();
        chk("in_ready after release", in_ready, 1);

        // ---------------- table ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].tag);
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            if (vecs[i].cmd == 4'hA) begin
                cyc = 0;
                rdy_low = 1'b1;
                while (!out_valid && cyc < 100) begin
                    if (in_ready) rdy_low = 1'b0;
                    tick();
                    cyc++;
                end
                chk($sformatf("vec%0d mul latency", i), cyc, W);
                chk($sformatf("vec%0d mul in_ready low", i), rdy_low, 1);
            end else begin
                chk($sformatf("vec%0d out_valid", i), out_valid, 1);
            end
            chk($sformatf("vec%0d result", i), result, vecs[i].res);
            chk($sformatf("vec%0d nzcv_err", i), {n, z, c, v, err},
                {vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].err});
            chk($sformatf("vec%0d tag", i), tag_out, vecs[i].tag);
            tick();
            chk($sformatf("vec%0d drained", i), out_valid, 0);
        end

        // ---------------- back-to-back throughput ----------------
        for (int i = 0; i < 4; i++) begin
            drive(4'h2, 32'd100, 32'(i), 1'b0, 4'(i));
            #1;
            chk("b2b in_ready", in_ready, 1);
            tick();
            chk("b2b out_valid", out_valid, 1);
            chk("b2b result", result, 32'd100 + 32'(i));
            chk("b2b tag", tag_out, i);
        end
        in_valid = 1'b0;
        tick();

        // ---------------- backpressure: ADD held, ORR waits ----------------
        out_ready = 1'b0;
        drive(4'h2, 32'd5, 32'd6, 1'b0, 4'h3);
        #1;
        chk("bp add in_ready", in_ready, 1);
        tick();
        drive(4'h7, 32'h0F, 32'hF0, 1'b0, 4'h5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp in_ready low", in_ready, 0);
            chk("bp held valid", out_valid, 1);
            chk("bp held result", result, 32'd11);
            chk("bp held tag", tag_out, 4'h3);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp handoff in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp orr valid", out_valid, 1);
        chk("bp orr result", result, 32'hFF);
        chk("bp orr tag", tag_out, 4'h5);
        tick();
        chk("bp drained", out_valid, 0);

        // ---------------- MUL product held under backpressure ----------------
        out_ready = 1'b0;
        drive(4'hA, 32'd3, 32'd7, 1'b1, 4'h9);
        #1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("mhold latency", cyc, W);
        for (int i = 0; i < 3; i++) begin
            chk("mhold result", result, 32'd21);
            chk("mhold tag", tag_out, 4'h9);
            chk("mhold in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("mhold release in_ready", in_ready, 1);
        tick();
        chk("mhold drained", out_valid, 0);

        // ---------------- flush of a held result ----------------
        out_ready = 1'b0;
        drive(4'h2, 32'd1, 32'd2, 1'b0, 4'h1);
        #1;
        tick();
        in_valid = 1'b0;
        chk("fl held valid", out_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl held cleared", out_valid, 0);
        out_ready = 1'b1;

        // ---------------- flush mid-MUL ----------------
        drive(4'hA, 32'd1234, 32'd5678, 1'b0, 4'h2);
        #1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        #1;
        chk("fl in_ready during flush", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl out_valid", out_valid, 0);
        chk("fl in_ready", in_ready, 1);
        stayed_low = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) stayed_low = 1'b0;
            tick();
        end
        chk("fl no late product", stayed_low, 1);

        // ---------------- reset mid-MUL ----------------
        drive(4'h2, 32'h80000000, 32'h0, 1'b1, 4'h7);
        #1;
        tick();
        chk("rm pre result", result, 32'h80000000);
        drive(4'hA, 32'd9, 32'd9, 1'b1, 4'h6);
        #1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("rm out_valid", out_valid, 0);
        chk("rm result", result, 0);
        chk("rm flags", {n, z, c, v, err}, 0);
        chk("rm tag", tag_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        stayed_low = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) stayed_low = 1'b0;
            tick();
        end
        chk("rm no product", stayed_low, 1);

        // ---------------- random phase with scoreboard ----------------
        accepts = 0;
        q.delete();
        for (int t = 0; t < 3000; t++) begin
            int r;
            flush     = ($urandom_range(0, 99) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 15);
            if (r == 0) begin
                cmd = 4'(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(11, 15));
            end else if (r == 1) begin
                cmd = 4'hA;
            end else begin
                cmd = 4'($urandom_range(1, 9));
            end
            val1 = $urandom;
            val2 = $urandom;
            if ($urandom_range(0, 7) == 0) val1 = 32'hFFFFFFFF;
            if ($urandom_range(0, 7) == 0) val2 = 32'h80000000;
            if ($urandom_range(0, 9) == 0) val2 = val1;
            carry_in = 1'($urandom_range(0, 1));
            tag_in   = 4'($urandom_range(0, 15));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd spurious out_valid", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd result", result, e.res);
                    chk("rnd nzcv_err", {n, z, c, v, err}, {e.n, e.z, e.c, e.v, e.err});
                    chk("rnd tag", tag_out, e.tag);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cmd, val1, val2, carry_in, tag_in));
                accepts++;
            end
            if (flush) q.delete();
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && q.size() > 0; t++) begin
            #1;
            if (out_valid) begin
                e = q.pop_front();
                chk("drain result", result, e.res);
                chk("drain nzcv_err", {n, z, c, v, err}, {e.n, e.z, e.c, e.v, e.err});
                chk("drain tag", tag_out, e.tag);
            end
            tick();
        end
        chk("rnd queue empty", q.size(), 0);
        chk("rnd enough accepts", (accepts > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked execution ALU for the ARM core's EX stage. Adds a registered output with NZCV flag generation, an iterative shift-add multiplier, a destination tag, a flush, and valid/ready flow control on both sides. One operation is in flight at a time. Single-cycle ops return one cycle after acceptance; MUL returns WIDTH cycles after acceptance.

## Interface
- WIDTH, 32: operand and result width. Must be at least 2.
- TAG_W, 4: width of the pass-through destination tag.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of in-flight and pending work.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- cmd  in  4  operation code.
- val1, val2  in  WIDTH  operands.
- carry_in  in  1  current C flag (for ADC/SBC); also the shifter carry passed through on logical ops.
- tag_in  in  TAG_W  destination tag.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  result.
- n, z, c, v  out  1 each  flags for the result.
- tag_out  out  TAG_W  tag of the result.
- err  out  1  cmd was illegal.

## Operation
- Opcodes and results:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: val1+val2.
  - 0011 ADC: val1+val2+carry_in.
  - 0100 SUB: val1-val2.
  - 0101 SBC: val1-val2-!carry_in.
  - 0110 AND, 0111 ORR, 1000 EOR: bitwise ops.
  - 1010 MUL: low WIDTH bits of val1*val2.
  - All other codes are illegal.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD/ADC: c = carry out of bit WIDTH-1.
  - SUB/SBC: c = NOT borrow, i.e. 1 when there is no borrow.
  - v = signed overflow: the operands' sign bits match (ADD) or differ (SUB), and the result sign differs from val1's sign.
- Logical ops, MOV, MVN and MUL: c = carry_in, v = 0. The status register owner preserves V for these ops.
- All ops: n = result[WIDTH-1]; z = (result == 0).
- Illegal cmd is still accepted and returns a single-cycle result: result = 0, n=0, z=1, c=carry_in, v=0, err=1. err = 0 for every legal op.
- States:
  - IDLE: no multiply in progress.
  - MUL: iterating. Holds multiplicand, multiplier, accumulator, carry and tag registers plus a counter of $clog2(WIDTH)+1 bits.
  - MDONE: product ready, but the output register is still occupied.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
- Accept: in_valid && in_ready at a rising edge.
  - Single-cycle op: loads result, flags, tag and err, and sets out_valid.
  - MUL: loads operands, clears the accumulator and counter, and goes to MUL. The output register is not written.
- MUL iteration, one per cycle:
  - if multiplier[0], acc += multiplicand (mod 2^WIDTH);
  - multiplicand <<= 1; multiplier >>= 1; count += 1.
- After the WIDTH-th iteration:
  - if (!out_valid || out_ready), the product is written to the output register and state returns to IDLE;
  - otherwise state goes to MDONE and waits for that condition, then writes and returns to IDLE.
- Output register: out_valid clears on out_ready unless a new result is loaded on the same edge. result, flags and tag are held stable while out_valid && !out_ready.
- flush, on the edge it is sampled high:
  - clears out_valid;
  - returns state to IDLE and discards any multiply;
  - ignores in_valid on that edge.
  - flush wins over every simultaneous event.

## Timing
- Reset (async assert): out_valid=0, state=IDLE, result=0, n=z=c=v=0, tag_out=0, err=0, counter=0. in_ready goes high one cycle after rst_n deasserts, provided flush=0.
- Single-cycle op accepted at edge k: out_valid is high from edge k.
- Back-to-back throughput with out_ready=1: one op per cycle.
- MUL accepted at edge k: iterations occur at edges k+1..k+WIDTH; out_valid is high from edge k+WIDTH if the output is free. in_ready stays low from edge k until the product is written.
- Reset asserted mid-MUL: all state clears immediately and no result is produced.
- An op accepted on the same edge as an output handoff: the new result replaces the old one with no bubble.

## Test plan
- ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000, n=0 z=1 c=1 v=0, out_valid one cycle after accept; ADD 0x7FFFFFFF+1 -> 0x80000000, n=1 v=1 c=0.
- SUB 5-7 -> 0xFFFFFFFE, n=1 c=0 v=0; SBC 10-3 with carry_in=0 -> 6, c=1; ADC 1+1 with carry_in=1 -> 3.
- MUL 1234*5678 -> 0x006AE9BC, z=0, out_valid exactly 32 cycles after accept, in_ready low throughout; MUL 0x80000000*2 -> 0, z=1.
- out_ready=0 while issuing ADD then ORR -> ORR held with in_ready=0, ADD result and tag stable; one cycle of out_ready=1 -> ORR result appears on the next edge.
- MUL with out_valid stuck high -> state holds in MDONE with no result change; out_ready pulse -> product written on the next edge.
- flush after 10 MUL iterations -> out_valid stays 0 and in_ready high the next cycle; rst_n low mid-MUL -> all outputs 0 immediately; cmd 1111 -> result 0, z=1, err=1.
